unidad_control_multiciclo: RTL and testbench

Multicycle MIPS control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clock cycles, replacing the single-cycle opcode decoder. It supports a configurable memory latency, a pipeline-wide stall input and an illegal-opcode flag. It sits between the instruction register (IR) opcode field and the datapath mux selects and write enables.

---
 rtl/unidad_control_multiciclo.sv | 199 +++++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle MIPS control unit (Moore FSM) sequencing
// fetch, decode, execute, memory and write-back with configurable memory latency.
//
// Parameters:
//   MEM_LAT  cycles per memory access (FETCH, MEMRD, MEMWR), 1..15
//   ALUOP_W  AluOp width, >= 3; bits above bit 2 are always 0
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   op[5:0]              IR opcode, sampled only in DECODE
//   stall                freezes state, cnt and latched opcode; masks write enables
//   PCWrite/PCWriteCond  PC write, PC write qualified by ALU zero
//   PCSource[1:0]        00 ALU, 01 ALUOut, 10 jump target
//   IorD                 memory address: 0 PC, 1 ALUOut
//   MemRead/MemToWrite   memory read / write
//   IRWrite              IR load
//   MemToReg             write-back data: 1 MDR, 0 ALUOut
//   RegDst               destination: 1 rd, 0 rt
//   RegWrite             register file write
//   AluSrcA              0 PC, 1 A
//   AluSrcB[1:0]         00 B, 01 4, 10 sign-ext imm, 11 shifted sign-ext imm
//   AluOp                000 add, 001 sub, 010 funct decode
//   Illegal              one-cycle pulse in DECODE on an unsupported opcode
//   estado[3:0]          current state for debug
module unidad_control_multiciclo #(
   parameter int MEM_LAT = 2,
   parameter int ALUOP_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic               stall,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic [1:0]         PCSource,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemToWrite,
   output logic               IRWrite,
   output logic               MemToReg,
   output logic               RegDst,
   output logic               RegWrite,
   output logic               AluSrcA,
   output logic [1:0]         AluSrcB,
   output logic [ALUOP_W-1:0] AluOp,
   output logic               Illegal,
   output logic [3:0]         estado
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [5:0] opLatched;
   logic       running;
   logic       go;
   logic       memState;
   logic       lastCnt;
   logic       opLegal;
   logic       pcWriteRaw;
   logic       pcWriteCondRaw;
   logic       irWriteRaw;
   logic       regWriteRaw;
   logic       memWriteRaw;
   logic [2:0] aluOpRaw;

   // running stays low through reset and its first edge, so the first FETCH
   // cycle begins on the first rising edge after rst_n is released and no
   // write enable can fire while reset is asserted.
   assign go       = running && !stall;
   assign memState = state inside {FETCH, MEMRD, MEMWR};
   assign lastCnt  = cnt == CNT_LAST;
   assign opLegal  = op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FETCH;
         cnt       <= '0;
         opLatched <= '0;
         running   <= 1'b0;
      end else begin
         running <= 1'b1;
         if (go) begin
            if (memState && !lastCnt) begin
               cnt <= cnt + 4'd1;
            end else begin
               cnt <= '0;
               case (state)
                  FETCH:  state <= DECODE;
                  DECODE: begin
                     opLatched <= op;
                     state <= (op == OP_LW || op == OP_SW) ? MEMADR :
                              (op == OP_RTYPE)             ? EXEC   :
                              (op == OP_BEQ)               ? BRANCH :
                              (op == OP_J)                 ? JUMP   :
                              (op == OP_ADDI)              ? ADDIEX : FETCH;
                  end
                  MEMADR: state <= (opLatched == OP_SW) ? MEMWR : MEMRD;
                  MEMRD:  state <= MEMWB;
                  EXEC:   state <= RWB;
                  ADDIEX: state <= ADDIWB;
                  default: state <= FETCH;
               endcase
            end
         end
      end
   end

   always_comb begin
      pcWriteRaw     = 1'b0;
      pcWriteCondRaw = 1'b0;
      irWriteRaw     = 1'b0;
      regWriteRaw    = 1'b0;
      memWriteRaw    = 1'b0;
      PCSource       = 2'b00;
      IorD           = 1'b0;
      MemRead        = 1'b0;
      MemToReg       = 1'b0;
      RegDst         = 1'b0;
      AluSrcA        = 1'b0;
      AluSrcB        = 2'b00;
      aluOpRaw       = 3'b000;
      case (state)
         FETCH: begin
            MemRead    = 1'b1;
            AluSrcB    = 2'b01;
            irWriteRaw = lastCnt;
            pcWriteRaw = lastCnt;
         end
         DECODE: AluSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            AluSrcA = 1'b1;
            AluSrcB = 2'b10;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWR: begin
            memWriteRaw = 1'b1;
            IorD        = 1'b1;
         end
         MEMWB: begin
            MemToReg    = 1'b1;
            regWriteRaw = 1'b1;
         end
         EXEC: begin
            AluSrcA  = 1'b1;
            aluOpRaw = 3'b010;
         end
         RWB: begin
            RegDst      = 1'b1;
            regWriteRaw = 1'b1;
         end
         ADDIWB: regWriteRaw = 1'b1;
         BRANCH: begin
            AluSrcA        = 1'b1;
            aluOpRaw       = 3'b001;
            pcWriteCondRaw = 1'b1;
            PCSource       = 2'b01;
         end
         JUMP: begin
            pcWriteRaw = 1'b1;
            PCSource   = 2'b10;
         end
         default: ;
      endcase
   end

   // Write enables are masked by stall so a frozen cycle repeats without
   // producing duplicate writes; selects and MemRead stay state-decoded.
   assign PCWrite     = pcWriteRaw && go;
   assign PCWriteCond = pcWriteCondRaw && go;
   assign IRWrite     = irWriteRaw && go;
   assign RegWrite    = regWriteRaw && go;
   assign MemToWrite  = memWriteRaw && go;
   assign Illegal     = go && state == DECODE && !opLegal;
   assign AluOp       = ALUOP_W'(aluOpRaw);
   assign estado      = state;
endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb_unidad_control_multiciclo: randomized self-checking bench for the multicycle control unit
module tb_unidad_control_multiciclo;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] BAD  = 6'b111111;
   // outs bit map: 17 PCWrite, 16 PCWriteCond, 15:14 PCSource, 13 IorD, 12 MemRead,
   // 11 MemToWrite, 10 IRWrite, 9 MemToReg, 8 RegDst, 7 RegWrite, 6 AluSrcA,
   // 5:4 AluSrcB, 3:1 AluOp, 0 Illegal
   localparam logic [17:0] WR_MASK  = 18'h30C81;
   localparam logic [17:0] RST_OUTS = 18'h01010;
   localparam int LAT0 = 2;
   localparam int LAT1 = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opIn [2];
   logic        stallIn [2];
   wire  [17:0] outs0;
   wire  [17:0] outs1;
   wire  [3:0]  est0;
   wire  [3:0]  est1;
   wire  [3:0]  aluOp1;
   int          nChecks = 0;
   int          nFails = 0;
   int          pos [2];
   int          idx [2];
   int          stallLeft [2];
   logic [5:0]  opc [2];
   logic        forceLw;
   logic        randomPhase;
   logic        didStall;
   logic [5:0]  plan [7] = '{LW, RT, BEQ, BAD, SW, ADDI, JMP};
   logic [5:0]  legalOps [6] = '{LW, SW, RT, BEQ, JMP, ADDI};

   always #5 clk = ~clk;

   unidad_control_multiciclo #(.MEM_LAT(LAT0), .ALUOP_W(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .op(opIn[0]), .stall(stallIn[0]),
      .PCWrite(outs0[17]), .PCWriteCond(outs0[16]), .PCSource(outs0[15:14]),
      .IorD(outs0[13]), .MemRead(outs0[12]), .MemToWrite(outs0[11]), .IRWrite(outs0[10]),
      .MemToReg(outs0[9]), .RegDst(outs0[8]), .RegWrite(outs0[7]), .AluSrcA(outs0[6]),
      .AluSrcB(outs0[5:4]), .AluOp(outs0[3:1]), .Illegal(outs0[0]), .estado(est0)
   );

   unidad_control_multiciclo #(.MEM_LAT(LAT1), .ALUOP_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .op(opIn[1]), .stall(stallIn[1]),
      .PCWrite(outs1[17]), .PCWriteCond(outs1[16]), .PCSource(outs1[15:14]),
      .IorD(outs1[13]), .MemRead(outs1[12]), .MemToWrite(outs1[11]), .IRWrite(outs1[10]),
      .MemToReg(outs1[9]), .RegDst(outs1[8]), .RegWrite(outs1[7]), .AluSrcA(outs1[6]),
      .AluSrcB(outs1[5:4]), .AluOp(aluOp1), .Illegal(outs1[0]), .estado(est1)
   );
   assign outs1[3:1] = aluOp1[2:0];

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic isLegal(input logic [5:0] o);
      return o inside {LW, SW, RT, BEQ, JMP, ADDI};
   endfunction

   function automatic int latOf(input int d);
      return d == 0 ? LAT0 : LAT1;
   endfunction

   // Total cycles of one instruction, straight from the cycle-count rules.
   function automatic int instrLen(input int lat, input logic [5:0] o);
      if (o == LW) return 2 * lat + 3;
      if (o == SW) return 2 * lat + 2;
      if (o == RT || o == ADDI) return lat + 3;
      if (o == BEQ || o == JMP) return lat + 2;
      return lat + 1;
   endfunction

   // Expected {estado, outs} for cycle pos of an instruction with opcode o.
   function automatic logic [21:0] expRec(input int lat, input logic [5:0] o, input int pos);
      logic [3:0]  s;
      logic [17:0] v;
      int          k;
      s = 4'd0;
      v = '0;
      k = pos - lat - 1;
      if (pos < lat) begin
         v[12] = 1'b1;
         v[5:4] = 2'b01;
         if (pos == lat - 1) begin
            v[10] = 1'b1;
            v[17] = 1'b1;
         end
      end else if (pos == lat) begin
         s = 4'd1;
         v[5:4] = 2'b11;
         v[0] = !isLegal(o);
      end else if (o == LW || o == SW) begin
         if (k == 0) begin
            s = 4'd2;
            v[6] = 1'b1;
            v[5:4] = 2'b10;
         end else if (k <= lat) begin
            s = (o == LW) ? 4'd3 : 4'd5;
            v[13] = 1'b1;
            if (o == LW) v[12] = 1'b1;
            else v[11] = 1'b1;
         end else begin
            s = 4'd4;
            v[9] = 1'b1;
            v[7] = 1'b1;
         end
      end else if (o == RT) begin
         if (k == 0) begin
            s = 4'd6;
            v[6] = 1'b1;
            v[3:1] = 3'b010;
         end else begin
            s = 4'd7;
            v[8] = 1'b1;
            v[7] = 1'b1;
         end
      end else if (o == ADDI) begin
         if (k == 0) begin
            s = 4'd10;
            v[6] = 1'b1;
            v[5:4] = 2'b10;
         end else begin
            s = 4'd11;
            v[7] = 1'b1;
         end
      end else if (o == BEQ) begin
         s = 4'd8;
         v[6] = 1'b1;
         v[3:1] = 3'b001;
         v[16] = 1'b1;
         v[15:14] = 2'b01;
      end else if (o == JMP) begin
         s = 4'd9;
         v[17] = 1'b1;
         v[15:14] = 2'b10;
      end
      return {s, v};
   endfunction

   task automatic pickOp(input int d);
      logic [5:0] o;
      if (forceLw) o = LW;
      else if (idx[d] < 7) o = plan[idx[d]];
      else if ($urandom_range(0, 6) == 0) begin
         o = 6'($urandom);
         for (int t = 0; t < 64 && isLegal(o); t++) o = 6'($urandom);
         if (isLegal(o)) o = BAD;
      end else o = legalOps[$urandom_range(0, 5)];
      opc[d] = o;
      idx[d]++;
      pos[d] = 0;
   endtask

   task automatic resetCheck(input string tag);
      checkEq({tag, " estado0"}, 32'(est0), 32'd0);
      checkEq({tag, " outs0"}, 32'(outs0), 32'(RST_OUTS));
      checkEq({tag, " estado1"}, 32'(est1), 32'd0);
      checkEq({tag, " outs1"}, 32'(outs1), 32'(RST_OUTS));
   endtask

   // Called #1 after a rising edge: drive, check at the falling edge, advance model.
   task automatic cycle();
      logic [21:0] e;
      for (int d = 0; d < 2; d++) begin
         if (stallLeft[d] > 0) begin
            stallIn[d] = 1'b1;
            stallLeft[d]--;
         end else if (d == 0 && idx[0] == 2 && pos[0] == 1 && !didStall) begin
            didStall = 1'b1;
            stallIn[0] = 1'b1;
            stallLeft[0] = 2;
         end else stallIn[d] = randomPhase && $urandom_range(0, 4) == 0;
         opIn[d] = (pos[d] == latOf(d)) ? opc[d] : 6'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         e = expRec(latOf(d), opc[d], pos[d]);
         checkEq($sformatf("estado dut%0d op=%b pos=%0d", d, opc[d], pos[d]),
                 32'(d == 0 ? est0 : est1), 32'(e[21:18]));
         checkEq($sformatf("outs dut%0d op=%b pos=%0d stall=%0b", d, opc[d], pos[d], stallIn[d]),
                 32'(d == 0 ? outs0 : outs1), 32'(stallIn[d] ? (e[17:0] & ~WR_MASK) : e[17:0]));
      end
      checkEq("aluOp1 upper bit", 32'(aluOp1[3]), 32'd0);
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (!stallIn[d]) begin
            pos[d]++;
            if (pos[d] == instrLen(latOf(d), opc[d])) pickOp(d);
         end
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      forceLw = 1'b0;
      randomPhase = 1'b0;
      didStall = 1'b0;
      for (int d = 0; d < 2; d++) begin
         opIn[d] = '0;
         stallIn[d] = 1'b0;
         pos[d] = 0;
         idx[d] = 0;
         stallLeft[d] = 0;
         opc[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetCheck("inReset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      resetCheck("afterRelease");
      @(posedge clk);
      #1;
      pickOp(0);
      pickOp(1);
      repeat (40) cycle();
      randomPhase = 1'b1;
      repeat (600) cycle();
      randomPhase = 1'b0;
      forceLw = 1'b1;
      n = 0;
      while (!(opc[0] == LW && pos[0] == LAT0 + 2) && n < 200) begin
         cycle();
         n++;
      end
      checkEq("reach MEMRD within budget", 32'(n < 200), 32'd1);
      checkEq("estado before abort", 32'(est0), 32'd3);
      rst_n = 1'b0;
      #1;
      resetCheck("midMemrd");
      @(negedge clk);
      resetCheck("midMemrdHold");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      forceLw = 1'b0;
      @(negedge clk);
      resetCheck("postAbort");
      @(posedge clk);
      #1;
      pickOp(0);
      pickOp(1);
      randomPhase = 1'b1;
      repeat (60) cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
